// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared state encoding and datapath width for mac_scheduler
package mac_sched_pkg;
    localparam int MAC_DATA_W = 16;
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} schedState;
endpackage

// File: rtl/mac_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first pending requester after the round-robin pointer
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [IDX_W-1:0] ptr,
    output logic             anyGrant,
    output logic [IDX_W-1:0] grantIdx,
    output logic [NREQ-1:0]  grantOneHot
);
    always_comb begin
        anyGrant = 1'b0;
        grantIdx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!anyGrant && pending[(int'(ptr) + k) % NREQ]) begin
                anyGrant = 1'b1;
                grantIdx = IDX_W'((int'(ptr) + k) % NREQ);
            end
        end
        grantOneHot = anyGrant ? NREQ'(1) << grantIdx : '0;
    end
endmodule

// File: rtl/mac_scheduler.sv
// mac_scheduler: time-shares one accumulate-every-clock MAC between NREQ dot-product requesters
module mac_scheduler
    import mac_sched_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = MAC_DATA_W,
    parameter int LEN_W  = 8,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_start,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    input  logic [NREQ*DATA_W-1:0]   req_a,
    input  logic [NREQ*DATA_W-1:0]   req_b,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          req_done,
    output logic [DATA_W-1:0]        req_result,
    output logic [DATA_W-1:0]        mac_a,
    output logic [DATA_W-1:0]        mac_b,
    output logic                     mac_clr,
    input  logic [DATA_W-1:0]        mac_op,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant
);
    schedState state, stateN;
    logic [IDX_W-1:0] grantN, rrPtr, rrN;
    logic [NREQ-1:0] pending, pendingN, pendClr, startOk, grantOH, readyN, doneN;
    logic [LEN_W-1:0] lenQ [NREQ];
    logic [LEN_W-1:0] cnt, cntN;
    logic [DATA_W-1:0] macAN, macBN, resultN, curA, curB;
    logic macClrN, anyGrant, hs;
    logic [IDX_W-1:0] arbIdx;
    logic [NREQ-1:0] arbOH;

    rr_arbiter #(.NREQ(NREQ)) arb (
        .pending(pending),
        .ptr(rrPtr),
        .anyGrant(anyGrant),
        .grantIdx(arbIdx),
        .grantOneHot(arbOH)
    );

    assign busy = state != IDLE;
    assign grantOH = NREQ'(1) << grant;
    assign curA = req_a[int'(grant)*DATA_W +: DATA_W];
    assign curB = req_b[int'(grant)*DATA_W +: DATA_W];
    assign hs = req_valid[grant] & req_ready[grant];
    // a granted requester cannot queue a second job until its current one leaves the FSM
    assign startOk = req_start & ~pending & ~(busy ? grantOH : '0);
    assign pendingN = (pending & ~pendClr) | startOk;

    always_comb begin
        stateN = state;
        grantN = grant;
        rrN = rrPtr;
        cntN = cnt;
        pendClr = '0;
        macAN = '0;
        macBN = '0;
        macClrN = 1'b0;
        readyN = req_ready;
        doneN = '0;
        resultN = req_result;
        case (state)
            IDLE: if (anyGrant) begin
                grantN = arbIdx;
                pendClr = arbOH;
                cntN = lenQ[arbIdx];
                macClrN = 1'b1;
                stateN = CLEAR;
            end
            CLEAR: begin
                stateN = cnt == '0 ? DONE : STREAM;
                readyN = cnt == '0 ? '0 : grantOH;
            end
            STREAM: if (hs) begin
                macAN = curA;
                macBN = curB;
                cntN = cnt - 1'b1;
                if (cnt == LEN_W'(1)) begin
                    readyN = '0;
                    stateN = DRAIN;
                end
            end
            DRAIN: stateN = DONE;
            DONE: begin
                resultN = mac_op;
                doneN = grantOH;
                rrN = grant;
                stateN = IDLE;
            end
            default: stateN = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            rrPtr <= IDX_W'(NREQ - 1);
            pending <= '0;
            cnt <= '0;
            mac_a <= '0;
            mac_b <= '0;
            mac_clr <= 1'b1;
            req_ready <= '0;
            req_done <= '0;
            req_result <= '0;
            for (int i = 0; i < NREQ; i++) lenQ[i] <= '0;
        end else begin
            state <= stateN;
            grant <= grantN;
            rrPtr <= rrN;
            pending <= pendingN;
            cnt <= cntN;
            mac_a <= macAN;
            mac_b <= macBN;
            mac_clr <= macClrN;
            req_ready <= readyN;
            req_done <= doneN;
            req_result <= resultN;
            for (int i = 0; i < NREQ; i++)
                if (startOk[i]) lenQ[i] <= req_len[i*LEN_W +: LEN_W];
        end
    end
endmodule

// File: tb/tb_mac_scheduler.sv
// tb_mac_scheduler: directed jobs against a behavioural MAC with a done/result scoreboard
module tb_mac_scheduler;
    logic clk = 0, rst = 0;
    logic [1:0] reqStart = '0, reqValid = '0;
    logic [15:0] reqLen = '0;
    logic [31:0] reqA = '0, reqB = '0;
    logic [1:0] reqReady, reqDone;
    logic [15:0] reqResult, macA, macB, macOp;
    logic macClr, busy;
    logic [0:0] grant;

    int checks = 0, errors = 0;
    int doneCnt [2] = '{0, 0};
    int clrCycles, rdyCycles;
    logic [16:0] expQ [$];
    logic [16:0] expE;
    logic [31:0] pairs [2][4];

    mac_scheduler #(.NREQ(2), .DATA_W(16), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .req_start(reqStart), .req_len(reqLen),
        .req_a(reqA), .req_b(reqB), .req_valid(reqValid), .req_ready(reqReady),
        .req_done(reqDone), .req_result(reqResult), .mac_a(macA), .mac_b(macB),
        .mac_clr(macClr), .mac_op(macOp), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge macClr)
        if (macClr) macOp <= '0;
        else macOp <= macOp + macA * macB;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && reqDone != 2'b00) begin
            if (reqDone[0]) doneCnt[0]++;
            if (reqDone[1]) doneCnt[1]++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: req_done=%b result=%0d", reqDone, reqResult);
            end else begin
                expE = expQ.pop_front();
                check("done_index", {30'd0, reqDone}, 32'(2'b01 << expE[16]));
                check("result", {16'd0, reqResult}, {16'd0, expE[15:0]});
            end
        end
    end

    task automatic setPair(input int r, input int i, input logic [15:0] a, input logic [15:0] b);
        pairs[r][i] = {a, b};
    endtask

    task automatic startJob(input int r, input int len);
        @(negedge clk);
        reqStart[r] = 1'b1;
        reqLen[r*8 +: 8] = len[7:0];
        @(negedge clk);
        reqStart[r] = 1'b0;
    endtask

    task automatic startBoth(input int len0, input int len1);
        @(negedge clk);
        reqStart = 2'b11;
        reqLen = {len1[7:0], len0[7:0]};
        @(negedge clk);
        reqStart = 2'b00;
    endtask

    task automatic feed(input int r, input int n, input int gap);
        int t;
        for (int i = 0; i < n; i++) begin
            reqA[r*16 +: 16] = pairs[r][i][31:16];
            reqB[r*16 +: 16] = pairs[r][i][15:0];
            reqValid[r] = 1'b1;
            t = 0;
            while (!reqReady[r] && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: req %0d pair %0d got no ready, required ready within 300 cycles", r, i);
                break;
            end
            @(negedge clk);
            if (gap > 0 && i < n - 1) begin
                reqValid[r] = 1'b0;
                repeat (gap) begin
                    @(negedge clk);
                    check("gap_mac_ab", {macA, macB}, 32'd0);
                end
            end
        end
        reqValid[r] = 1'b0;
    endtask

    task automatic waitDone();
        int t = 0;
        clrCycles = 0;
        rdyCycles = 0;
        while (expQ.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
            if (macClr) clrCycles++;
            if (reqReady != 2'b00) rdyCycles++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d results outstanding, required 0", expQ.size());
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetVals(input string tag);
        check({tag, "_mac_clr"}, {31'd0, macClr}, 32'd1);
        check({tag, "_mac_ab"}, {macA, macB}, 32'd0);
        check({tag, "_ready_done"}, {28'd0, reqReady, reqDone}, 32'd0);
        check({tag, "_result"}, {16'd0, reqResult}, 32'd0);
        check({tag, "_busy_grant"}, {30'd0, busy, grant}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        checkResetVals("reset");
        rst = 1'b1;
        @(negedge clk);
        check("idle_mac_clr", {31'd0, macClr}, 32'd0);

        // simultaneous starts after reset: req0 wins first
        setPair(0, 0, 16'd3, 16'd3);
        setPair(1, 0, 16'd2, 16'd2);
        expQ.push_back({1'b0, 16'd9});
        expQ.push_back({1'b1, 16'd4});
        startBoth(1, 1);
        fork
            feed(0, 1, 0);
            feed(1, 1, 0);
        join
        waitDone();

        setPair(0, 0, 16'd2, 16'd3);
        setPair(0, 1, 16'd4, 16'd5);
        setPair(0, 2, 16'hFFFF, 16'd7);
        expQ.push_back({1'b0, 16'd19});
        startJob(0, 3);
        feed(0, 3, 0);
        waitDone();

        // last grant was req0, so req1 goes first now
        setPair(0, 0, 16'hFFFD, 16'd4);
        setPair(1, 0, 16'd6, 16'd7);
        expQ.push_back({1'b1, 16'd42});
        expQ.push_back({1'b0, 16'd65524});
        startBoth(1, 1);
        fork
            feed(0, 1, 0);
            feed(1, 1, 0);
        join
        waitDone();

        expQ.push_back({1'b1, 16'd0});
        startJob(1, 0);
        waitDone();
        check("len0_clr_cycles", clrCycles, 32'd1);
        check("len0_ready_cycles", rdyCycles, 32'd0);

        setPair(0, 0, 16'd300, 16'd300);
        setPair(0, 1, 16'd200, 16'd200);
        expQ.push_back({1'b0, 16'd64464});
        startJob(0, 2);
        feed(0, 2, 0);
        waitDone();
        expQ.push_back({1'b0, 16'd64464});
        startJob(0, 2);
        feed(0, 2, 3);
        waitDone();

        // restart while granted must be dropped
        setPair(0, 0, 16'd1, 16'd1);
        setPair(0, 1, 16'd2, 16'd2);
        d0 = doneCnt[0];
        expQ.push_back({1'b0, 16'd5});
        startJob(0, 2);
        @(negedge clk);
        reqStart[0] = 1'b1;
        reqLen[7:0] = 8'd5;
        @(negedge clk);
        reqStart[0] = 1'b0;
        feed(0, 2, 0);
        waitDone();
        repeat (20) @(negedge clk);
        check("restart_busy", {31'd0, busy}, 32'd0);
        check("restart_done_count", doneCnt[0] - d0, 32'd1);

        // reset in the middle of STREAM
        setPair(0, 0, 16'd5, 16'd5);
        d0 = doneCnt[0];
        startJob(0, 3);
        feed(0, 1, 0);
        rst = 1'b0;
        @(negedge clk);
        checkResetVals("midreset");
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_no_done", doneCnt[0] - d0, 32'd0);
        setPair(1, 0, 16'd5, 16'd5);
        expQ.push_back({1'b1, 16'd25});
        startJob(1, 1);
        feed(1, 1, 0);
        waitDone();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
